// File: rtl/rv32i_issue_ctrl.sv
// Single-entry RV32I decode/issue controller with a pending-write scoreboard.
// Define RV32I_ISSUE_WB_BYPASS_EN to let same-cycle writebacks clear hazards.

package rv32i_issue_pkg;

  typedef struct packed {
    logic        illegal;
    logic        reg_write;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        alt_op;
    logic        use_imm;
    logic        use_pc;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        lui;
    logic        fence;
    logic        system;
    logic [31:0] imm;
  } decode_ctrl_t;

  // Unused register fields are left zero so they never match a pending bit.
  function automatic decode_ctrl_t rv32i_decoder(input logic [31:0] instr);
    decode_ctrl_t c;
    logic [6:0]   opc;
    logic [6:0]   f7;
    logic [2:0]   f3;
    logic         legal;
    c      = '0;
    opc    = instr[6:0];
    f7     = instr[31:25];
    f3     = instr[14:12];
    legal  = 1'b1;
    c.funct3 = f3;
    case (opc)
      7'b0110111: begin
        c.lui = 1'b1; c.reg_write = 1'b1; c.rd = instr[11:7]; c.use_imm = 1'b1;
        c.imm = {instr[31:12], 12'h000};
      end
      7'b0010111: begin
        c.use_pc = 1'b1; c.reg_write = 1'b1; c.rd = instr[11:7]; c.use_imm = 1'b1;
        c.imm = {instr[31:12], 12'h000};
      end
      7'b1101111: begin
        c.jal = 1'b1; c.reg_write = 1'b1; c.rd = instr[11:7];
        c.imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      7'b1100111: begin
        legal = (f3 == 3'b000);
        c.jalr = 1'b1; c.reg_write = 1'b1; c.rd = instr[11:7]; c.rs1 = instr[19:15];
        c.use_imm = 1'b1; c.imm = {{20{instr[31]}}, instr[31:20]};
      end
      7'b1100011: begin
        legal = (f3 != 3'b010) && (f3 != 3'b011);
        c.branch = 1'b1; c.rs1 = instr[19:15]; c.rs2 = instr[24:20];
        c.imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      7'b0000011: begin
        legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        c.mem_read = 1'b1; c.reg_write = 1'b1; c.rd = instr[11:7]; c.rs1 = instr[19:15];
        c.use_imm = 1'b1; c.imm = {{20{instr[31]}}, instr[31:20]};
      end
      7'b0100011: begin
        legal = (f3 <= 3'b010);
        c.mem_write = 1'b1; c.rs1 = instr[19:15]; c.rs2 = instr[24:20]; c.use_imm = 1'b1;
        c.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      7'b0010011: begin
        case (f3)
          3'b001:  legal = (f7 == 7'b0000000);
          3'b101:  legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
          default: legal = 1'b1;
        endcase
        c.reg_write = 1'b1; c.rd = instr[11:7]; c.rs1 = instr[19:15]; c.use_imm = 1'b1;
        c.alt_op = (f3 == 3'b101) && f7[5];
        c.imm = {{20{instr[31]}}, instr[31:20]};
      end
      7'b0110011: begin
        legal = (f7 == 7'b0000000) ||
                ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
        c.reg_write = 1'b1; c.rd = instr[11:7]; c.rs1 = instr[19:15]; c.rs2 = instr[24:20];
        c.alt_op = f7[5];
      end
      7'b0001111: begin
        legal   = (f3 == 3'b000);
        c.fence = 1'b1;
      end
      7'b1110011: begin
        legal    = (instr == 32'h0000_0073) || (instr == 32'h0010_0073);
        c.system = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      c         = '0;
      c.illegal = 1'b1;
    end
    return c;
  endfunction

endpackage

module rv32i_issue_ctrl
  import rv32i_issue_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         fetch_valid_i,
  output logic         fetch_ready_o,
  input  logic [31:0]  fetch_instr_i,
  input  logic [31:0]  fetch_pc_i,
  output logic         issue_valid_o,
  input  logic         issue_ready_i,
  output decode_ctrl_t issue_ctrl_o,
  output logic [31:0]  issue_pc_o,
  input  logic         wb_valid_i,
  input  logic [4:0]   wb_rd_i,
  input  logic         flush_i,
  output logic         trap_valid_o,
  output logic [31:0]  trap_pc_o,
  output logic [3:0]   inflight_o
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_TRAP  = 2'd2;
  localparam logic [3:0] LP_MAX   = 4'(MAX_INFLIGHT);

  logic [1:0]   r_state;
  logic [1:0]   w_state_d;
  decode_ctrl_t r_ctrl;
  decode_ctrl_t w_dec;
  logic [31:0]  r_pc;
  logic [31:0]  r_pending;
  logic [31:0]  w_pending_d;
  logic [3:0]   r_inflight;
  logic [3:0]   w_inflight_d;

  logic         w_wb_hit;
  logic [31:0]  w_wb_onehot;
  logic [31:0]  w_set_onehot;
  logic [31:0]  w_pend_chk;
  logic [3:0]   w_cnt_chk;
  logic         w_rd_writes;
  logic         w_hazard;
  logic         w_issue_fire;
  logic         w_fetch_fire;

  assign w_dec       = rv32i_decoder(fetch_instr_i);
  assign w_wb_hit    = wb_valid_i && r_pending[wb_rd_i];
  assign w_wb_onehot = w_wb_hit ? (32'd1 << wb_rd_i) : 32'd0;
  assign w_rd_writes = r_ctrl.reg_write && (r_ctrl.rd != 5'd0);

`ifdef RV32I_ISSUE_WB_BYPASS_EN
  assign w_pend_chk = r_pending & ~w_wb_onehot;
  assign w_cnt_chk  = r_inflight - {3'd0, w_wb_hit};
`else
  assign w_pend_chk = r_pending;
  assign w_cnt_chk  = r_inflight;
`endif

  assign w_hazard = w_pend_chk[r_ctrl.rs1] | w_pend_chk[r_ctrl.rs2] |
                    (r_ctrl.reg_write & w_pend_chk[r_ctrl.rd]) |
                    (w_rd_writes & (w_cnt_chk == LP_MAX));

  assign issue_valid_o = (r_state == ST_FULL) && !w_hazard && !flush_i;
  assign w_issue_fire  = issue_valid_o && issue_ready_i;
  // Refill in the issue-fire cycle keeps a 1/cycle stream flowing.
  assign fetch_ready_o = !flush_i && ((r_state == ST_EMPTY) || w_issue_fire);
  assign w_fetch_fire  = fetch_valid_i && fetch_ready_o;

  assign issue_ctrl_o = r_ctrl;
  assign issue_pc_o   = r_pc;
  assign trap_valid_o = (r_state == ST_TRAP);
  assign trap_pc_o    = trap_valid_o ? r_pc : 32'd0;
  assign inflight_o   = r_inflight;

  always_comb begin
    w_state_d = r_state;
    if (flush_i) begin
      w_state_d = ST_EMPTY;
    end else if (w_fetch_fire) begin
      w_state_d = w_dec.illegal ? ST_TRAP : ST_FULL;
    end else if (w_issue_fire) begin
      w_state_d = ST_EMPTY;
    end
  end

  // Flush leaves the scoreboard alone: issued writes still retire.
  always_comb begin
    w_set_onehot = (w_issue_fire && w_rd_writes) ? (32'd1 << r_ctrl.rd) : 32'd0;
    w_pending_d  = ((r_pending & ~w_wb_onehot) | w_set_onehot) & 32'hFFFF_FFFE;
    w_inflight_d = r_inflight;
    case ({w_set_onehot != 32'd0, w_wb_hit})
      2'b10:   w_inflight_d = r_inflight + 4'd1;
      2'b01:   w_inflight_d = r_inflight - 4'd1;
      default: w_inflight_d = r_inflight;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_EMPTY;
      r_ctrl     <= '0;
      r_pc       <= 32'd0;
      r_pending  <= 32'd0;
      r_inflight <= 4'd0;
    end else begin
      r_state    <= w_state_d;
      r_pending  <= w_pending_d;
      r_inflight <= w_inflight_d;
      if (w_fetch_fire) begin
        r_ctrl <= w_dec;
        r_pc   <= fetch_pc_i;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_issue_ctrl.sv
// Directed self-checking bench for rv32i_issue_ctrl (MAX_INFLIGHT = 4).
module tb_rv32i_issue_ctrl;
  import rv32i_issue_pkg::*;

`ifdef RV32I_ISSUE_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic         clk;
  logic         rst_ni;
  logic         fetch_valid_i;
  logic         fetch_ready_o;
  logic [31:0]  fetch_instr_i;
  logic [31:0]  fetch_pc_i;
  logic         issue_valid_o;
  logic         issue_ready_i;
  decode_ctrl_t issue_ctrl_o;
  logic [31:0]  issue_pc_o;
  logic         wb_valid_i;
  logic [4:0]   wb_rd_i;
  logic         flush_i;
  logic         trap_valid_o;
  logic [31:0]  trap_pc_o;
  logic [3:0]   inflight_o;

  int checks;
  int failures;

  rv32i_issue_ctrl #(.MAX_INFLIGHT(4)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .fetch_valid_i (fetch_valid_i),
    .fetch_ready_o (fetch_ready_o),
    .fetch_instr_i (fetch_instr_i),
    .fetch_pc_i    (fetch_pc_i),
    .issue_valid_o (issue_valid_o),
    .issue_ready_i (issue_ready_i),
    .issue_ctrl_o  (issue_ctrl_o),
    .issue_pc_o    (issue_pc_o),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_i       (wb_rd_i),
    .flush_i       (flush_i),
    .trap_valid_o  (trap_valid_o),
    .trap_pc_o     (trap_pc_o),
    .inflight_o    (inflight_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drive one cycle's inputs just after the falling edge, then settle.
  task automatic step(input logic fv, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ir, input logic wbv, input logic [4:0] wbrd, input logic fl);
    @(negedge clk);
    fetch_valid_i = fv;
    fetch_instr_i = ins;
    fetch_pc_i    = pc;
    issue_ready_i = ir;
    wb_valid_i    = wbv;
    wb_rd_i       = wbrd;
    flush_i       = fl;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic wb(input logic [4:0] rd);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, rd, 1'b0);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    fetch_valid_i = 1'b0; fetch_instr_i = 32'd0; fetch_pc_i = 32'd0;
    issue_ready_i = 1'b0; wb_valid_i = 1'b0; wb_rd_i = 5'd0; flush_i = 1'b0;
    #3;
    checks++;
    if ({issue_valid_o, trap_valid_o, inflight_o} !== 6'd0) begin
      failures++;
      $display("FAIL reset_status got=%b exp=000000", {issue_valid_o, trap_valid_o, inflight_o});
    end
    checks++;
    if (issue_ctrl_o !== '0 || issue_pc_o !== 32'd0 || trap_pc_o !== 32'd0) begin
      failures++;
      $display("FAIL reset_regs ctrl=%h pc=%h tpc=%h exp=0", issue_ctrl_o, issue_pc_o, trap_pc_o);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    idle();
    checks++;
    if (fetch_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_fetch_ready got=%b exp=1", fetch_ready_o);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 32'h0050_0093, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0);  // ADDI x1,x0,5
    checks++;
    if (fetch_ready_o !== 1'b1 || issue_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first_accept fr=%b iv=%b exp fr=1 iv=0", fetch_ready_o, issue_valid_o);
    end
    step(1'b1, 32'h0070_0113, 32'h4, 1'b1, 1'b0, 5'd0, 1'b0);  // ADDI x2,x0,7
    checks++;
    if (issue_valid_o !== 1'b1 || fetch_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL b2b_issue1 iv=%b fr=%b exp iv=1 fr=1", issue_valid_o, fetch_ready_o);
    end
    checks++;
    if (issue_pc_o !== 32'h0 || issue_ctrl_o.rd !== 5'd1 || issue_ctrl_o.imm !== 32'd5) begin
      failures++;
      $display("FAIL b2b_decode1 pc=%h rd=%0d imm=%0d exp pc=0 rd=1 imm=5",
               issue_pc_o, issue_ctrl_o.rd, issue_ctrl_o.imm);
    end
    idle();
    checks++;
    if (issue_valid_o !== 1'b1 || issue_pc_o !== 32'h4 || inflight_o !== 4'd1) begin
      failures++;
      $display("FAIL b2b_issue2 iv=%b pc=%h inf=%0d exp iv=1 pc=4 inf=1",
               issue_valid_o, issue_pc_o, inflight_o);
    end
    idle();
    checks++;
    if (issue_valid_o !== 1'b0 || inflight_o !== 4'd2) begin
      failures++;
      $display("FAIL b2b_after iv=%b inf=%0d exp iv=0 inf=2", issue_valid_o, inflight_o);
    end
    wb(5'd7);
    wb(5'd1);
    checks++;
    if (inflight_o !== 4'd2) begin
      failures++;
      $display("FAIL wb_nonpending_ignored inf=%0d exp=2", inflight_o);
    end
    wb(5'd2);
    checks++;
    if (inflight_o !== 4'd1) begin
      failures++;
      $display("FAIL wb_x1 inf=%0d exp=1", inflight_o);
    end
    idle();
    checks++;
    if (inflight_o !== 4'd0) begin
      failures++;
      $display("FAIL wb_x2 inf=%0d exp=0", inflight_o);
    end
  endtask

  task automatic test_raw();
    step(1'b1, 32'h0010_0193, 32'h10, 1'b1, 1'b0, 5'd0, 1'b0);  // ADDI x3,x0,1
    step(1'b1, 32'h0031_8233, 32'h14, 1'b1, 1'b0, 5'd0, 1'b0);  // ADD x4,x3,x3
    idle();
    checks++;
    if (issue_valid_o !== 1'b0 || fetch_ready_o !== 1'b0 || inflight_o !== 4'd1) begin
      failures++;
      $display("FAIL raw_stall iv=%b fr=%b inf=%0d exp iv=0 fr=0 inf=1",
               issue_valid_o, fetch_ready_o, inflight_o);
    end
    checks++;
    if (issue_ctrl_o.rs1 !== 5'd3 || issue_ctrl_o.rs2 !== 5'd3 || issue_ctrl_o.rd !== 5'd4) begin
      failures++;
      $display("FAIL raw_decode rs1=%0d rs2=%0d rd=%0d exp 3 3 4",
               issue_ctrl_o.rs1, issue_ctrl_o.rs2, issue_ctrl_o.rd);
    end
    idle();
    checks++;
    if (issue_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL raw_stall2 iv=%b exp=0", issue_valid_o);
    end
    wb(5'd3);
    checks++;
    if (issue_valid_o !== BYP) begin
      failures++;
      $display("FAIL raw_wb_cycle iv=%b exp=%b", issue_valid_o, BYP);
    end
    idle();
    checks++;
    if (issue_valid_o !== !BYP || inflight_o !== (BYP ? 4'd1 : 4'd0)) begin
      failures++;
      $display("FAIL raw_after_wb iv=%b inf=%0d exp iv=%b inf=%0d",
               issue_valid_o, inflight_o, !BYP, BYP ? 1 : 0);
    end
    idle();
    checks++;
    if (issue_valid_o !== 1'b0 || inflight_o !== 4'd1) begin
      failures++;
      $display("FAIL raw_issued iv=%b inf=%0d exp iv=0 inf=1", issue_valid_o, inflight_o);
    end
    wb(5'd4);
    idle();
  endtask

  task automatic test_inflight_limit();
    logic [31:0] addis [5];
    addis[0] = 32'h0010_0093; addis[1] = 32'h0010_0113; addis[2] = 32'h0010_0193;
    addis[3] = 32'h0010_0213; addis[4] = 32'h0010_0293;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, addis[i], 32'h20 + 32'(4 * i), 1'b1, 1'b0, 5'd0, 1'b0);
    end
    idle();
    checks++;
    if (inflight_o !== 4'd4 || issue_valid_o !== 1'b0 || fetch_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL limit_stall inf=%0d iv=%b fr=%b exp inf=4 iv=0 fr=0",
               inflight_o, issue_valid_o, fetch_ready_o);
    end
    idle();
    checks++;
    if (issue_valid_o !== 1'b0 || issue_ctrl_o.rd !== 5'd5) begin
      failures++;
      $display("FAIL limit_hold iv=%b rd=%0d exp iv=0 rd=5", issue_valid_o, issue_ctrl_o.rd);
    end
    wb(5'd1);
    checks++;
    if (issue_valid_o !== BYP) begin
      failures++;
      $display("FAIL limit_wb_cycle iv=%b exp=%b", issue_valid_o, BYP);
    end
    idle();
    checks++;
    if (issue_valid_o !== !BYP || inflight_o !== (BYP ? 4'd4 : 4'd3)) begin
      failures++;
      $display("FAIL limit_release iv=%b inf=%0d exp iv=%b inf=%0d",
               issue_valid_o, inflight_o, !BYP, BYP ? 4 : 3);
    end
    idle();
    checks++;
    if (inflight_o !== 4'd4 || issue_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL limit_x5_issued inf=%0d iv=%b exp inf=4 iv=0", inflight_o, issue_valid_o);
    end
    for (int r = 2; r <= 5; r++) wb(5'(r));
    idle();
    checks++;
    if (inflight_o !== 4'd0) begin
      failures++;
      $display("FAIL limit_drain inf=%0d exp=0", inflight_o);
    end
  endtask

  task automatic test_fence();
    step(1'b1, 32'h0FF0_000F, 32'h40, 1'b1, 1'b0, 5'd0, 1'b0);
    idle();
    checks++;
    if (issue_valid_o !== 1'b1 || issue_ctrl_o.reg_write !== 1'b0 || issue_ctrl_o.fence !== 1'b1) begin
      failures++;
      $display("FAIL fence_issue iv=%b rw=%b fence=%b exp 1 0 1",
               issue_valid_o, issue_ctrl_o.reg_write, issue_ctrl_o.fence);
    end
    idle();
    checks++;
    if (inflight_o !== 4'd0 || issue_valid_o !== 1'b0 || fetch_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL fence_after inf=%0d iv=%b fr=%b exp 0 0 1",
               inflight_o, issue_valid_o, fetch_ready_o);
    end
  endtask

  task automatic test_illegal();
    step(1'b1, 32'h0000_0000, 32'h100, 1'b1, 1'b0, 5'd0, 1'b0);
    step(1'b1, 32'h0010_0093, 32'h104, 1'b1, 1'b0, 5'd0, 1'b0);
    checks++;
    if (trap_valid_o !== 1'b1 || trap_pc_o !== 32'h100) begin
      failures++;
      $display("FAIL trap_latch tv=%b tpc=%h exp tv=1 tpc=100", trap_valid_o, trap_pc_o);
    end
    checks++;
    if (fetch_ready_o !== 1'b0 || issue_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL trap_block fr=%b iv=%b exp 0 0", fetch_ready_o, issue_valid_o);
    end
    step(1'b1, 32'h0010_0093, 32'h104, 1'b1, 1'b0, 5'd0, 1'b0);
    checks++;
    if (trap_valid_o !== 1'b1 || trap_pc_o !== 32'h100) begin
      failures++;
      $display("FAIL trap_hold tv=%b tpc=%h exp tv=1 tpc=100", trap_valid_o, trap_pc_o);
    end
    step(1'b1, 32'h0010_0093, 32'h104, 1'b1, 1'b0, 5'd0, 1'b1);
    checks++;
    if (fetch_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL trap_flush_cycle fr=%b exp=0", fetch_ready_o);
    end
    idle();
    checks++;
    if (trap_valid_o !== 1'b0 || fetch_ready_o !== 1'b1 || trap_pc_o !== 32'd0) begin
      failures++;
      $display("FAIL trap_cleared tv=%b fr=%b tpc=%h exp 0 1 0",
               trap_valid_o, fetch_ready_o, trap_pc_o);
    end
  endtask

  task automatic test_flush_pending();
    logic seen;
    step(1'b1, 32'h0010_0293, 32'h200, 1'b1, 1'b0, 5'd0, 1'b0);  // ADDI x5,x0,1
    step(1'b1, 32'h0050_2023, 32'h204, 1'b1, 1'b0, 5'd0, 1'b0);  // SW x5,0(x0)
    idle();
    checks++;
    if (issue_valid_o !== 1'b0 || issue_pc_o !== 32'h204 || inflight_o !== 4'd1) begin
      failures++;
      $display("FAIL flush_setup iv=%b pc=%h inf=%0d exp iv=0 pc=204 inf=1",
               issue_valid_o, issue_pc_o, inflight_o);
    end
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b1);
    seen = issue_valid_o;
    for (int i = 0; i < 3; i++) begin
      idle();
      seen = seen | issue_valid_o;
    end
    checks++;
    if (seen !== 1'b0 || fetch_ready_o !== 1'b1 || inflight_o !== 4'd1) begin
      failures++;
      $display("FAIL flush_drop seen=%b fr=%b inf=%0d exp 0 1 1", seen, fetch_ready_o, inflight_o);
    end
    wb(5'd5);
    idle();
    checks++;
    if (inflight_o !== 4'd0) begin
      failures++;
      $display("FAIL flush_late_wb inf=%0d exp=0", inflight_o);
    end
  endtask

  task automatic test_stall_async_reset();
    step(1'b1, 32'h0010_0413, 32'h300, 1'b1, 1'b0, 5'd0, 1'b0);  // ADDI x8,x0,1
    step(1'b1, 32'h0010_0493, 32'h304, 1'b1, 1'b0, 5'd0, 1'b0);  // ADDI x9,x0,1
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checks++;
    if (issue_valid_o !== 1'b1 || issue_pc_o !== 32'h304 || inflight_o !== 4'd1) begin
      failures++;
      $display("FAIL stall_hold iv=%b pc=%h inf=%0d exp iv=1 pc=304 inf=1",
               issue_valid_o, issue_pc_o, inflight_o);
    end
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checks++;
    if (issue_valid_o !== 1'b1 || issue_pc_o !== 32'h304 || issue_ctrl_o.rd !== 5'd9) begin
      failures++;
      $display("FAIL stall_stable iv=%b pc=%h rd=%0d exp iv=1 pc=304 rd=9",
               issue_valid_o, issue_pc_o, issue_ctrl_o.rd);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (issue_valid_o !== 1'b0 || inflight_o !== 4'd0 || trap_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_status iv=%b inf=%0d tv=%b exp 0 0 0",
               issue_valid_o, inflight_o, trap_valid_o);
    end
    checks++;
    if (issue_pc_o !== 32'd0 || issue_ctrl_o !== '0 || fetch_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL async_reset_regs pc=%h ctrl=%h fr=%b exp pc=0 ctrl=0 fr=1",
               issue_pc_o, issue_ctrl_o, fetch_ready_o);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    idle();
    checks++;
    if (inflight_o !== 4'd0 || issue_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL post_reset inf=%0d iv=%b exp 0 0", inflight_o, issue_valid_o);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_back_to_back();
    test_raw();
    test_inflight_limit();
    test_fence();
    test_illegal();
    test_flush_pending();
    test_stall_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
